rst_seq: RTL and testbench

- Consumes the raw testbench/board clock and asynchronous reset and produces staged, synchronously released resets for the system, ADC and Wishbone domains of the FMC150 test design.
- Gates release on a clock-generator lock indication and times out if lock never arrives.
- Sits directly downstream of the clock/reset generator and upstream of every DUT reset input.

---
 rtl/rst_seq.sv | 147 ++++++++++++++
 tb/tb_rst_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: staged reset release for the system, ADC and Wishbone domains.
// rstn_i asserts everything asynchronously; its release and locked_i are
// resynchronised to clk_sys_i. Releases are gated on lock, step through
// fixed-length stages, and a sticky timeout flags a lock that never arrives.
module rst_seq #(
    parameter int SYNC_STAGES  = 3,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk_sys_i,
    input  logic       rstn_i,
    input  logic       locked_i,
    input  logic       rst_req_i,
    output logic       rstn_sys_o,
    output logic       rstn_adc_o,
    output logic       rstn_wb_o,
    output logic       ready_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = (STAGE_DELAY > LOCK_TIMEOUT) ? STAGE_DELAY : LOCK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_REL_SYS   = 3'd2;
    localparam logic [2:0] S_REL_ADC   = 3'd3;
    localparam logic [2:0] S_REL_WB    = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_TIMEOUT   = 3'd6;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   rst_n_s;
    logic                   locked_s;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          timeout_nxt;
    logic          released;

    assign rst_n_s  = rst_sync[SYNC_STAGES-1];
    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign state_o  = state;

    // Reset-release synchronizer: clears at once, fills with ones on clk.
    always_ff @(posedge clk_sys_i or negedge rstn_i) begin
        if (!rstn_i) rst_sync <= '0;
        else         rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    // Lock synchronizer, cleared by reset so lock is re-qualified after it.
    always_ff @(posedge clk_sys_i or negedge rstn_i) begin
        if (!rstn_i) lock_sync <= '0;
        else         lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
    end

    // Next-state logic; an abort outranks any stage advance.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = timeout_o;
        released    = (state == S_REL_SYS) || (state == S_REL_ADC) ||
                      (state == S_REL_WB)  || (state == S_RUN);
        case (state)
            S_RESET: begin
                if (rst_n_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (rst_req_i) begin
                    cnt_nxt = '0;
                end else if (locked_s) begin
                    state_nxt = S_REL_SYS;
                    cnt_nxt   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt   = S_TIMEOUT;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_TIMEOUT: begin
                if (rst_req_i) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (locked_s) begin
                    state_nxt = S_REL_SYS;
                    cnt_nxt   = '0;
                end
            end
            S_REL_SYS, S_REL_ADC, S_REL_WB, S_RUN: begin
                if (rst_req_i || !locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (state != S_RUN) begin
                    if (cnt == STAGE_LAST) begin
                        state_nxt = state + 3'd1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_RESET;
                cnt_nxt   = '0;
            end
        endcase
        if (!released && (state != S_WAIT_LOCK) && (state != S_TIMEOUT) &&
            (state != S_RESET)) begin
            state_nxt = S_RESET;
        end
    end

    // State, counter and outputs; outputs are decoded from the next state
    // so they toggle on the same edge as the state register.
    always_ff @(posedge clk_sys_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_RESET;
            cnt        <= '0;
            timeout_o  <= 1'b0;
            rstn_sys_o <= 1'b0;
            rstn_adc_o <= 1'b0;
            rstn_wb_o  <= 1'b0;
            ready_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            timeout_o  <= timeout_nxt;
            rstn_sys_o <= (state_nxt >= S_REL_SYS) && (state_nxt <= S_RUN);
            rstn_adc_o <= (state_nxt >= S_REL_ADC) && (state_nxt <= S_RUN);
            rstn_wb_o  <= (state_nxt >= S_REL_WB)  && (state_nxt <= S_RUN);
            ready_o    <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: drives a default-parameter and a minimum-parameter rst_seq
// from shared inputs and compares both against a cycle reference model,
// plus timing checks on the recorded release/timeout edges.
module tb_rst_seq;

    localparam int SS = 3;

    logic clk = 1'b0;
    logic rstn;
    logic locked;
    logic req;

    logic       o_sys   [2];
    logic       o_adc   [2];
    logic       o_wb    [2];
    logic       o_rdy   [2];
    logic       o_tmo   [2];
    logic [2:0] o_state [2];

    always #5 clk = ~clk;

    rst_seq #(.SYNC_STAGES(SS), .STAGE_DELAY(16), .LOCK_TIMEOUT(1024)) u_dut (
        .clk_sys_i(clk), .rstn_i(rstn), .locked_i(locked), .rst_req_i(req),
        .rstn_sys_o(o_sys[0]), .rstn_adc_o(o_adc[0]), .rstn_wb_o(o_wb[0]),
        .ready_o(o_rdy[0]), .timeout_o(o_tmo[0]), .state_o(o_state[0])
    );

    rst_seq #(.SYNC_STAGES(SS), .STAGE_DELAY(1), .LOCK_TIMEOUT(2)) u_dut_min (
        .clk_sys_i(clk), .rstn_i(rstn), .locked_i(locked), .rst_req_i(req),
        .rstn_sys_o(o_sys[1]), .rstn_adc_o(o_adc[1]), .rstn_wb_o(o_wb[1]),
        .ready_o(o_rdy[1]), .timeout_o(o_tmo[1]), .state_o(o_state[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sync chains as an edge count and a lock history,
    // release progress as a phase number with a per-phase cycle count.
    int m_sd [2] = '{16, 1};
    int m_lt [2] = '{1024, 2};
    int m_ph [2];
    int m_cnt[2];
    int m_tmo[2];
    int rst_edges;
    bit lk_hist[SS];

    task automatic model_reset();
        rst_edges = 0;
        for (int k = 0; k < SS; k++) lk_hist[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_cnt[i] = 0; m_tmo[i] = 0;
        end
    endtask

    task automatic fsm_step(input int i, input bit rs, input bit lk);
        case (m_ph[i])
            0: if (rs) begin m_ph[i] = 1; m_cnt[i] = 0; end
            1: begin
                if (req) m_cnt[i] = 0;
                else if (lk) begin m_ph[i] = 2; m_cnt[i] = 0; end
                else if (m_cnt[i] + 1 == m_lt[i]) begin m_ph[i] = 6; m_tmo[i] = 1; end
                else m_cnt[i]++;
            end
            6: begin
                if (req) begin m_ph[i] = 1; m_cnt[i] = 0; end
                else if (lk) begin m_ph[i] = 2; m_cnt[i] = 0; end
            end
            default: begin
                if (req || !lk) begin m_ph[i] = 1; m_cnt[i] = 0; end
                else if (m_ph[i] < 5) begin
                    if (m_cnt[i] + 1 == m_sd[i]) begin m_ph[i]++; m_cnt[i] = 0; end
                    else m_cnt[i]++;
                end
            end
        endcase
    endtask

    task automatic model_edge();
        bit rs, lk;
        if (!rstn) begin
            model_reset();
        end else begin
            rs = (rst_edges >= SS);
            lk = lk_hist[SS-1];
            for (int k = SS - 1; k > 0; k--) lk_hist[k] = lk_hist[k-1];
            lk_hist[0] = locked;
            if (rst_edges < SS) rst_edges++;
            for (int i = 0; i < 2; i++) fsm_step(i, rs, lk);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_state", i), int'(o_state[i]), m_ph[i]);
            check($sformatf("u%0d_sys", i), int'(o_sys[i]), int'(m_ph[i] >= 2 && m_ph[i] <= 5));
            check($sformatf("u%0d_adc", i), int'(o_adc[i]), int'(m_ph[i] >= 3 && m_ph[i] <= 5));
            check($sformatf("u%0d_wb", i), int'(o_wb[i]), int'(m_ph[i] >= 4 && m_ph[i] <= 5));
            check($sformatf("u%0d_ready", i), int'(o_rdy[i]), int'(m_ph[i] == 5));
            check($sformatf("u%0d_timeout", i), int'(o_tmo[i]), m_tmo[i]);
        end
    endtask

    // Edge recorder: cycle index at which each output last rose / state entered.
    int cyc = 0;
    int t_state[2][8];
    int t_sys[2], t_adc[2], t_wb[2], t_rdy[2], t_tmo[2];
    logic [2:0] p_state[2];
    logic p_sys[2], p_adc[2], p_wb[2], p_rdy[2], p_tmo[2];

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < 2; i++) begin
            if (o_state[i] != p_state[i]) t_state[i][o_state[i]] = cyc;
            if (o_sys[i] && !p_sys[i]) t_sys[i] = cyc;
            if (o_adc[i] && !p_adc[i]) t_adc[i] = cyc;
            if (o_wb[i]  && !p_wb[i])  t_wb[i]  = cyc;
            if (o_rdy[i] && !p_rdy[i]) t_rdy[i] = cyc;
            if (o_tmo[i] && !p_tmo[i]) t_tmo[i] = cyc;
            p_state[i] = o_state[i]; p_sys[i] = o_sys[i]; p_adc[i] = o_adc[i];
            p_wb[i] = o_wb[i]; p_rdy[i] = o_rdy[i]; p_tmo[i] = o_tmo[i];
        end
    endtask

    initial begin
        int c0;
        int guard;
        rstn = 1'b0; locked = 1'b1; req = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            p_state[i] = '0; p_sys[i] = 0; p_adc[i] = 0; p_wb[i] = 0; p_rdy[i] = 0; p_tmo[i] = 0;
            t_sys[i] = -1; t_adc[i] = -1; t_wb[i] = -1; t_rdy[i] = -1; t_tmo[i] = -1;
            for (int s = 0; s < 8; s++) t_state[i][s] = -1;
        end
        #1 compare_all();
        repeat (2) cycle();

        // Power-up with lock present.
        rstn = 1'b1; c0 = cyc;
        repeat (70) cycle();
        check("pwr_sys_rise", t_sys[0] - c0, 5);
        check("pwr_adc_gap", t_adc[0] - t_sys[0], 16);
        check("pwr_wb_gap", t_wb[0] - t_adc[0], 16);
        check("pwr_rdy_gap", t_rdy[0] - t_wb[0], 16);
        check("pwr_wait_state", t_state[0][1] - c0, 4);
        check("min_rdy_rise", t_rdy[1] - c0, 8);

        // Lock lost long enough to time out, then recovers.
        locked = 1'b0;
        repeat (1100) cycle();
        check("tmo_delay", t_tmo[0] - t_state[0][1], 1024);
        check("min_tmo_delay", t_tmo[1] - t_state[1][1], 2);
        check("tmo_state", int'(o_state[0]), 6);
        locked = 1'b1;
        repeat (80) cycle();
        check("tmo_relock_ready", int'(o_rdy[0]), 1);
        check("tmo_sticky", int'(o_tmo[0]), 1);

        // Asynchronous reset mid-cycle while running.
        #2 rstn = 1'b0;
        model_reset();
        #1 compare_all();
        check("async_sys", int'(o_sys[0]), 0);
        check("async_tmo", int'(o_tmo[0]), 0);
        cycle();
        rstn = 1'b1; c0 = cyc;
        repeat (60) cycle();
        check("rerel_sys_rise", t_sys[0] - c0, 5);

        // One-cycle lock drop in S_RUN.
        locked = 1'b0; c0 = cyc;
        cycle();
        locked = 1'b1;
        repeat (60) cycle();
        check("glitch_abort", t_state[0][1] - c0, 4);
        check("glitch_sys_rise", t_sys[0] - c0, 5);
        check("glitch_rdy_rise", t_rdy[0] - c0, 53);

        // Soft reset landing on the ADC stage-advance edge.
        req = 1'b1; cycle(); req = 1'b0;
        guard = 0;
        while (o_state[0] != 3'd3 && guard < 100) begin cycle(); guard++; end
        check("reach_rel_adc", int'(o_state[0]), 3);
        repeat (15) cycle();
        req = 1'b1; cycle(); req = 1'b0;
        check("req_vs_adv_state", int'(o_state[0]), 1);
        check("req_vs_adv_sys", int'(o_sys[0]), 0);
        repeat (60) cycle();

        // Held soft reset without lock: no timeout may occur.
        locked = 1'b0; req = 1'b1;
        repeat (1100) cycle();
        check("hold_req_tmo", int'(o_tmo[0]), 0);
        check("hold_req_min_tmo", int'(o_tmo[1]), 0);
        check("hold_req_state", int'(o_state[1]), 1);
        req = 1'b0; locked = 1'b1;
        repeat (60) cycle();

        // Random traffic on lock, soft reset and board reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(63) == 0) locked = ~locked;
            req = ($urandom_range(49) == 0);
            rstn = ($urandom_range(399) != 0);
            cycle();
        end
        rstn = 1'b1;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
